// File: rtl/dram_arbiter_if.sv
// Bundle of the two requester ports and the memory command port of dram_arbiter.
// The arbiter uses the slave view; requesters and memory model use the master view.
interface dram_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          done0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          done1;
  logic [DW-1:0] rdata1;

  logic          mem_rd;
  logic          mem_wr;
  logic          mem_ref;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [1:0]    state;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata, mem_ack,
    output gnt0, done0, rdata0, gnt1, done1, rdata1,
           mem_rd, mem_wr, mem_ref, mem_addr, mem_wdata, state
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata, mem_ack,
    input  gnt0, done0, rdata0, gnt1, done1, rdata1,
           mem_rd, mem_wr, mem_ref, mem_addr, mem_wdata, state
  );
endinterface

// File: rtl/dram_arbiter.sv
// Round-robin two-port arbiter/sequencer for the small DRAM model, with
// periodic refresh that takes priority over new grants.
module dram_arbiter #(
  parameter int AW           = 4,
  parameter int DW           = 8,
  parameter int REF_INTERVAL = 64
) (
  input  logic          clk,
  input  logic          reset,
  dram_arbiter_if.slave bus
);

  localparam int            CW       = $clog2(REF_INTERVAL);
  localparam logic [CW-1:0] REF_LAST = CW'(REF_INTERVAL - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ACCESS  = 2'b01,
    S_REFRESH = 2'b10
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [CW-1:0] r_ref_cnt;
  logic          r_ref_pending;
  logic          r_last;
  logic          r_owner;
  logic          r_first;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_done0;
  logic          r_done1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic          w_take;
  logic          w_win;
  logic          w_acc_done;
  logic          w_ref_done;
  logic          w_expire;

  assign w_expire = (r_ref_cnt == REF_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_win       = 1'b0;
    w_acc_done  = 1'b0;
    w_ref_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_ref_pending) begin
          w_state_nxt = S_REFRESH;
        end else if (bus.req0 || bus.req1) begin
          // On a tie the port that was not served last wins.
          w_take      = 1'b1;
          w_win       = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (bus.mem_ack) begin
          w_acc_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_REFRESH: begin
        if (bus.mem_ack) begin
          w_ref_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ref_cnt     <= '0;
      r_ref_pending <= 1'b0;
      r_last        <= 1'b1;
      r_owner       <= 1'b0;
      r_first       <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_done0       <= 1'b0;
      r_done1       <= 1'b0;
      r_rdata0      <= '0;
      r_rdata1      <= '0;
    end else begin
      r_ref_cnt     <= w_expire ? '0 : r_ref_cnt + CW'(1);
      // A new expiry on the completing edge keeps the request alive.
      r_ref_pending <= w_expire | (r_ref_pending & ~w_ref_done);
      r_first       <= w_take;
      r_done0       <= w_acc_done & ~r_owner;
      r_done1       <= w_acc_done &  r_owner;
      if (w_take) begin
        r_owner <= w_win;
        r_last  <= w_win;
        r_we    <= w_win ? bus.we1    : bus.we0;
        r_addr  <= w_win ? bus.addr1  : bus.addr0;
        r_wdata <= w_win ? bus.wdata1 : bus.wdata0;
      end
      if (w_acc_done && !r_we) begin
        if (r_owner) r_rdata1 <= bus.mem_rdata;
        else         r_rdata0 <= bus.mem_rdata;
      end
    end
  end

  assign bus.gnt0      = r_first & ~r_owner;
  assign bus.gnt1      = r_first &  r_owner;
  assign bus.done0     = r_done0;
  assign bus.done1     = r_done1;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.mem_rd    = (r_state == S_ACCESS) & ~r_we;
  assign bus.mem_wr    = (r_state == S_ACCESS) &  r_we;
  assign bus.mem_ref   = (r_state == S_REFRESH);
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus random traffic, all compared
// cycle by cycle against a transaction-level reference model.
module tb_dram_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NREF = 8;
  localparam int VW = 2 + 4 + 2 * DW + 3 + AW + DW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  dram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dram_arbiter #(.AW(AW), .DW(DW), .REF_INTERVAL(NREF)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  logic [VW-1:0] obs;
  assign obs = {bus.state, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.rdata0, bus.rdata1,
                bus.mem_rd, bus.mem_wr, bus.mem_ref, bus.mem_addr, bus.mem_wdata};

  // Reference model: m_busy = -1 idle, 0/1 owning port, 2 refresh.
  int            m_edges = 0;
  int            m_busy = -1;
  logic          m_pend = 1'b0;
  logic          m_fresh = 1'b0;
  logic          m_last = 1'b1;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          m_done0 = 1'b0;
  logic          m_done1 = 1'b0;
  logic [DW-1:0] m_rd0 = '0;
  logic [DW-1:0] m_rd1 = '0;

  always @(posedge clk or negedge reset) begin : model
    logic expire;
    logic clr;
    int   w;
    if (!reset) begin
      m_edges = 0; m_busy = -1; m_pend = 0; m_fresh = 0; m_last = 1; m_we = 0;
      m_addr = '0; m_wdata = '0; m_done0 = 0; m_done1 = 0; m_rd0 = '0; m_rd1 = '0;
    end else begin
      m_edges++;
      expire  = (m_edges % NREF == 0);
      clr     = 0;
      m_done0 = 0;
      m_done1 = 0;
      if (m_busy < 0) begin
        m_fresh = 0;
        if (m_pend) m_busy = 2;
        else begin
          w = -1;
          if (bus.req0 && bus.req1) w = m_last ? 0 : 1;
          else if (bus.req0)        w = 0;
          else if (bus.req1)        w = 1;
          if (w >= 0) begin
            m_busy  = w;
            m_fresh = 1;
            m_last  = (w == 1);
            m_we    = (w == 1) ? bus.we1    : bus.we0;
            m_addr  = (w == 1) ? bus.addr1  : bus.addr0;
            m_wdata = (w == 1) ? bus.wdata1 : bus.wdata0;
          end
        end
      end else if (m_busy == 2) begin
        if (bus.mem_ack) begin clr = 1; m_busy = -1; end
      end else begin
        m_fresh = 0;
        if (bus.mem_ack) begin
          if (!m_we) begin
            if (m_busy == 1) m_rd1 = bus.mem_rdata;
            else             m_rd0 = bus.mem_rdata;
          end
          if (m_busy == 1) m_done1 = 1;
          else             m_done0 = 1;
          m_busy = -1;
        end
      end
      m_pend = expire || (m_pend && !clr);
    end
  end

  function automatic logic [VW-1:0] model_vec();
    logic [1:0] st;
    logic       acc;
    st  = (m_busy < 0) ? 2'b00 : (m_busy == 2) ? 2'b10 : 2'b01;
    acc = (m_busy == 0) || (m_busy == 1);
    return {st, (m_busy == 0) && m_fresh, (m_busy == 1) && m_fresh, m_done0, m_done1, m_rd0, m_rd1,
            acc && !m_we, acc && m_we, m_busy == 2, m_addr, m_wdata};
  endfunction

  // Memory model: acks after force_lat cycles (random 0..3 when negative).
  logic [DW-1:0] mem [16];
  int            force_lat = -1;
  logic          spur_en = 1'b0;
  int            mcnt = 0;
  int            mlat = 0;
  logic          mact = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      bus.mem_ack = 0; mact = 0; mcnt = 0;
    end else if (bus.mem_rd || bus.mem_wr || bus.mem_ref) begin
      if (!mact) begin
        mact = 1; mcnt = 0;
        mlat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
      end
      if (mcnt == mlat) begin
        bus.mem_ack   = 1;
        bus.mem_rdata = bus.mem_rd ? mem[bus.mem_addr] : DW'($urandom);
        if (bus.mem_wr) mem[bus.mem_addr] = bus.mem_wdata;
        mact = 0;
      end else begin
        bus.mem_ack   = 0;
        bus.mem_rdata = DW'($urandom);
        mcnt++;
      end
    end else begin
      mact          = 0;
      bus.mem_ack   = spur_en && ($urandom_range(0, 2) == 0);
      bus.mem_rdata = DW'($urandom);
    end
  end

  task automatic test_reset();
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
    #1 reset = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs !== '0) begin n_errors++; $display("FAIL reset_outputs obs=%h exp=0", obs); end
    n_checks++;
    if (obs !== model_vec()) begin n_errors++; $display("FAIL reset_model obs=%h exp=%h", obs, model_vec()); end
    reset = 1;
  endtask

  task automatic test_single_write();
    int   g = 0;
    int   w = 0;
    logic seen = 0;
    force_lat = 1;
    @(negedge clk);
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = AW'(1); bus.wdata0 = 8'hAA;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== model_vec()) begin n_errors++; $display("FAIL write_model t=%0t obs=%h exp=%h", $time, obs, model_vec()); end
      if (bus.gnt0) begin g++; bus.req0 = 0; end
      if (bus.mem_wr) begin
        w++;
        n_checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== {AW'(1), 8'hAA}) begin
          n_errors++; $display("FAIL write_cmd addr/data=%h/%h exp=1/aa", bus.mem_addr, bus.mem_wdata);
        end
      end
      if (bus.done0) begin
        seen = 1;
        n_checks++;
        if (bus.state !== 2'b00) begin n_errors++; $display("FAIL write_done_state got=%b exp=00", bus.state); end
      end
    end
    n_checks++;
    if (!seen) begin n_errors++; $display("FAIL write_done_timeout got=0 exp=1"); end
    n_checks++;
    if (g != 1) begin n_errors++; $display("FAIL write_gnt_count got=%0d exp=1", g); end
    n_checks++;
    if (w != 2) begin n_errors++; $display("FAIL write_cmd_cycles got=%0d exp=2", w); end
  endtask

  task automatic test_single_read();
    int   r = 0;
    logic seen = 0;
    force_lat = 2;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = AW'(1); bus.wdata1 = 8'h55;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== model_vec()) begin n_errors++; $display("FAIL read_model t=%0t obs=%h exp=%h", $time, obs, model_vec()); end
      if (bus.gnt1) bus.req1 = 0;
      if (bus.mem_rd) r++;
      if (bus.done1) begin
        seen = 1;
        n_checks++;
        if (bus.rdata1 !== 8'hAA) begin n_errors++; $display("FAIL read_rdata1 got=%h exp=aa", bus.rdata1); end
        n_checks++;
        if (bus.rdata0 !== 8'h00) begin n_errors++; $display("FAIL read_rdata0_hold got=%h exp=00", bus.rdata0); end
      end
    end
    n_checks++;
    if (!seen) begin n_errors++; $display("FAIL read_done_timeout got=0 exp=1"); end
    n_checks++;
    if (r != 3) begin n_errors++; $display("FAIL read_cmd_cycles got=%0d exp=3", r); end
  endtask

  task automatic test_contention();
    int last = -1;
    int n = 0;
    int p;
    force_lat = -1;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = AW'($urandom);
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = AW'($urandom);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== model_vec()) begin n_errors++; $display("FAIL contention_model t=%0t obs=%h exp=%h", $time, obs, model_vec()); end
      if (bus.gnt0 || bus.gnt1) begin
        p = bus.gnt1 ? 1 : 0;
        n_checks++;
        if ((bus.gnt0 && bus.gnt1) || p == last) begin
          n_errors++; $display("FAIL contention_alternate got=%0d prev=%0d", p, last);
        end
        last = p;
        n++;
      end
    end
    n_checks++;
    if (n < 6) begin n_errors++; $display("FAIL contention_grants got=%0d exp>=6", n); end
    bus.req0 = 0; bus.req1 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== model_vec()) begin n_errors++; $display("FAIL drain_model t=%0t obs=%h exp=%h", $time, obs, model_vec()); end
    end
  endtask

  task automatic test_spurious_ack();
    spur_en = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== model_vec()) begin n_errors++; $display("FAIL spurious_model t=%0t obs=%h exp=%h", $time, obs, model_vec()); end
      n_checks++;
      if (bus.done0 || bus.done1 || bus.gnt0 || bus.gnt1 || bus.state == 2'b01) begin
        n_errors++; $display("FAIL spurious_activity done=%b%b gnt=%b%b state=%b exp=none", bus.done0, bus.done1, bus.gnt0, bus.gnt1, bus.state);
      end
    end
    spur_en = 0;
  endtask

  task automatic test_refresh_priority();
    logic d0 = 0;
    logic ref_after = 0;
    logic g1 = 0;
    @(negedge clk) reset = 0;
    @(negedge clk) reset = 1;
    force_lat = 3;
    repeat (4) @(negedge clk);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = AW'(1);
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = AW'(2);
    for (int i = 0; i < 40 && !g1; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== model_vec()) begin n_errors++; $display("FAIL refresh_model t=%0t obs=%h exp=%h", $time, obs, model_vec()); end
      if (bus.gnt0) bus.req0 = 0;
      if (bus.done0) d0 = 1;
      if (bus.mem_ref && d0) ref_after = 1;
      if (bus.gnt1) begin
        g1 = 1;
        bus.req1 = 0;
        n_checks++;
        if (!ref_after) begin n_errors++; $display("FAIL refresh_before_gnt1 got=0 exp=1"); end
      end
    end
    n_checks++;
    if (!g1) begin n_errors++; $display("FAIL refresh_gnt1_timeout got=0 exp=1"); end
  endtask

  task automatic test_async_reset();
    logic g0 = 0;
    logic first = 0;
    force_lat = 6;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = AW'(3);
    for (int i = 0; i < 30 && !g0; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== model_vec()) begin n_errors++; $display("FAIL areset_model t=%0t obs=%h exp=%h", $time, obs, model_vec()); end
      if (bus.gnt0) begin g0 = 1; bus.req0 = 0; end
    end
    n_checks++;
    if (!g0) begin n_errors++; $display("FAIL areset_gnt_timeout got=0 exp=1"); end
    @(negedge clk);
    n_checks++;
    if (bus.mem_rd !== 1'b1) begin n_errors++; $display("FAIL areset_pre_rd got=%b exp=1", bus.mem_rd); end
    #2 reset = 0;
    #1;
    n_checks++;
    if ({bus.mem_rd, bus.state, bus.gnt0, bus.done0} !== 5'b0) begin
      n_errors++; $display("FAIL areset_immediate rd/state/gnt/done=%b/%b/%b/%b exp=0", bus.mem_rd, bus.state, bus.gnt0, bus.done0);
    end
    @(negedge clk) reset = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.done0 !== 1'b0 || obs !== model_vec()) begin
        n_errors++; $display("FAIL areset_no_done t=%0t obs=%h exp=%h", $time, obs, model_vec());
      end
    end
    bus.req0 = 1; bus.req1 = 1; bus.we0 = 0; bus.we1 = 0;
    for (int i = 0; i < 20 && !first; i++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) begin
        first = 1;
        n_checks++;
        if (!bus.gnt0 || bus.gnt1) begin n_errors++; $display("FAIL areset_first_tie gnt=%b%b exp=10", bus.gnt0, bus.gnt1); end
      end
    end
    n_checks++;
    if (!first) begin n_errors++; $display("FAIL areset_tie_timeout got=0 exp=1"); end
    bus.req0 = 0; bus.req1 = 0;
  endtask

  task automatic test_random();
    force_lat = -1;
    spur_en = 1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== model_vec()) begin n_errors++; $display("FAIL random_model t=%0t obs=%h exp=%h", $time, obs, model_vec()); end
      if (bus.req0 && bus.gnt0 && $urandom_range(0, 3) != 0) bus.req0 = 0;
      else if (!bus.req0 && $urandom_range(0, 2) == 0) begin
        bus.req0 = 1; bus.we0 = 1'($urandom); bus.addr0 = AW'($urandom); bus.wdata0 = DW'($urandom);
      end
      if (bus.req1 && bus.gnt1 && $urandom_range(0, 3) != 0) bus.req1 = 0;
      else if (!bus.req1 && $urandom_range(0, 2) == 0) begin
        bus.req1 = 1; bus.we1 = 1'($urandom); bus.addr1 = AW'($urandom); bus.wdata1 = DW'($urandom);
      end
    end
    spur_en = 0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_spurious_ack();
    test_refresh_priority();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
